// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage between fetch and igen/execute.
// Accepts {pc, insn} from fetch through a 2-entry skid buffer (output
// register + skid register) and presents registered decoded fields.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   flush_i                drop all held and incoming instructions
//   valid_i/ready_o        fetch-side handshake, pc_i/insn_i payload
//   valid_o/ready_i        downstream handshake
//   pc_o, insn_o           PC and raw instruction of the decoded entry
//   opcode_o .. funct7_o   decoded fields, zeroed where the format lacks them
//   illegal_o              unrecognised encoding (meaningful with valid_o)
module decode_stage #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic              illegal_o
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic              or_valid;
  logic              sk_valid;
  logic [AWIDTH-1:0] sk_pc;
  logic [DWIDTH-1:0] sk_insn;

  logic              accept;
  logic              fire_out;
  logic              or_free;
  logic              or_load;
  logic              sk_load;

  logic [AWIDTH-1:0] ld_pc;
  logic [DWIDTH-1:0] ld_insn;

  logic [6:0]        d_opcode;
  logic [4:0]        d_rd;
  logic [2:0]        d_funct3;
  logic [4:0]        d_rs1;
  logic [4:0]        d_rs2;
  logic [6:0]        d_funct7;
  logic              d_illegal;

  assign ready_o  = !sk_valid;
  assign valid_o  = or_valid;
  assign accept   = valid_i & ready_o;
  assign fire_out = or_valid & ready_i;
  assign or_free  = !or_valid | fire_out;

  // The skid entry is always older than the input, so it has priority for OR.
  assign ld_pc   = sk_valid ? sk_pc   : pc_i;
  assign ld_insn = sk_valid ? sk_insn : insn_i;
  assign or_load = or_free & (sk_valid | accept);
  // Input goes to the skid when OR stays occupied, or when OR is refilled from SK.
  assign sk_load = accept & (sk_valid | !or_free);

  always_comb begin
    d_opcode  = ld_insn[6:0];
    d_rd      = ld_insn[11:7];
    d_funct3  = ld_insn[14:12];
    d_rs1     = ld_insn[19:15];
    d_rs2     = '0;
    d_funct7  = '0;
    d_illegal = 1'b0;
    case (d_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        d_funct3 = '0;
        d_rs1    = '0;
      end
      OP_BRANCH, OP_STORE: begin
        d_rd  = '0;
        d_rs2 = ld_insn[24:20];
      end
      OP_OP: begin
        d_rs2    = ld_insn[24:20];
        d_funct7 = ld_insn[31:25];
      end
      OP_IMM: begin
        if (ld_insn[13:12] == 2'b01) d_funct7 = ld_insn[31:25];
      end
      OP_JALR, OP_LOAD, OP_FENCE, OP_SYSTEM: ;
      default: d_illegal = 1'b1;
    endcase
    if (ld_insn[1:0] != 2'b11) d_illegal = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (flush_i) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else begin
      if (or_free) begin
        or_valid <= sk_valid | accept;
        sk_valid <= sk_valid & accept;
      end else if (accept) begin
        sk_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_pc   <= '0;
      sk_insn <= '0;
    end else if (sk_load) begin
      sk_pc   <= pc_i;
      sk_insn <= insn_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o      <= '0;
      insn_o    <= '0;
      opcode_o  <= '0;
      rd_o      <= '0;
      funct3_o  <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      funct7_o  <= '0;
      illegal_o <= 1'b0;
    end else if (or_load) begin
      pc_o      <= ld_pc;
      insn_o    <= ld_insn;
      opcode_o  <= d_opcode;
      rd_o      <= d_rd;
      funct3_o  <= d_funct3;
      rs1_o     <= d_rs1;
      rs2_o     <= d_rs2;
      funct7_o  <= d_funct7;
      illegal_o <= d_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based occupancy model and a field-rule reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] insn_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [6:0]  funct7_o;
  logic        illegal_o;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  decode_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .insn_i(insn_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .funct7_o(funct7_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } item_t;

  item_t q[$];

  // Stage contents as an ordered list of at most two entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush_i) begin
      q.delete();
    end else begin
      int sz;
      item_t it;
      sz = q.size();
      if (sz > 0 && ready_i) void'(q.pop_front());
      if (valid_i && sz < 2) begin
        it.pc   = pc_i;
        it.insn = insn_i;
        q.push_back(it);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ill, uj, bs;
    chk("valid_o", {31'd0, valid_o}, {31'd0, q.size() > 0});
    chk("ready_o", {31'd0, ready_o}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      w  = q[0].insn;
      op = w[6:0];
      f3 = w[14:12];
      uj = op inside {7'h37, 7'h17, 7'h6F};
      bs = op inside {7'h63, 7'h23};
      ill = (w[1:0] != 2'b11) ||
            !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
      chk("pc_o",      pc_o, q[0].pc);
      chk("insn_o",    insn_o, w);
      chk("opcode_o",  {25'd0, opcode_o}, {25'd0, op});
      chk("rd_o",      {27'd0, rd_o},     bs ? 32'd0 : {27'd0, w[11:7]});
      chk("funct3_o",  {29'd0, funct3_o}, uj ? 32'd0 : {29'd0, f3});
      chk("rs1_o",     {27'd0, rs1_o},    uj ? 32'd0 : {27'd0, w[19:15]});
      chk("rs2_o",     {27'd0, rs2_o},    (bs || op == 7'h33) ? {27'd0, w[24:20]} : 32'd0);
      chk("funct7_o",  {25'd0, funct7_o},
          (op == 7'h33 || (op == 7'h13 && (f3 == 3'b001 || f3 == 3'b101))) ? {25'd0, w[31:25]} : 32'd0);
      chk("illegal_o", {31'd0, illegal_o}, {31'd0, ill});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w);
    valid_i = v;
    pc_i    = pc;
    insn_i  = w;
  endtask

  logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h0B};

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    #12;
    chk("rst valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst opcode_o", {25'd0, opcode_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // ADDI x1,x0,5 then sustained streaming
    ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'h0050_0093);
    tick();
    chk("addi valid", {31'd0, valid_o}, 32'd1);
    chk("addi opcode", {25'd0, opcode_o}, 32'h13);
    chk("addi rd", {27'd0, rd_o}, 32'd1);
    chk("addi illegal", {31'd0, illegal_o}, 32'd0);
    for (int i = 1; i < 6; i++) begin
      drive(1'b1, 32'(i * 4), 32'h0050_0093 + 32'(i << 7));
      tick();
      chk("stream ready", {31'd0, ready_o}, 32'd1);
    end

    // asynchronous reset while the stage holds data
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid_o", {31'd0, valid_o}, 32'd0);
    chk("midrst ready_o", {31'd0, ready_o}, 32'd1);
    chk("midrst opcode_o", {25'd0, opcode_o}, 32'd0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // backpressure: ADDI held, ADD in skid, SW waits at fetch
    ready_i = 1'b0;
    drive(1'b1, 32'h100, 32'h0050_0093);
    tick();
    drive(1'b1, 32'h104, 32'h0020_81B3);
    tick();
    drive(1'b1, 32'h108, 32'h0031_2023);
    tick();
    tick();
    chk("bp ready_o", {31'd0, ready_o}, 32'd0);
    chk("bp insn_o", insn_o, 32'h0050_0093);
    ready_i = 1'b1;
    tick();
    chk("bp add insn", insn_o, 32'h0020_81B3);
    chk("bp add rs2", {27'd0, rs2_o}, 32'd2);
    chk("bp add funct7", {25'd0, funct7_o}, 32'd0);
    tick();
    chk("bp sw insn", insn_o, 32'h0031_2023);
    chk("bp sw rd", {27'd0, rd_o}, 32'd0);
    chk("bp sw rs2", {27'd0, rs2_o}, 32'd3);
    drive(1'b0, '0, '0);
    tick();

    // flush with both entries full and a new input offered
    ready_i = 1'b0;
    drive(1'b1, 32'h200, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h204, 32'h0010_0013);
    tick();
    drive(1'b1, 32'h208, 32'h0020_0013);
    flush_i = 1'b1;
    tick();
    chk("flush valid_o", {31'd0, valid_o}, 32'd0);
    chk("flush ready_o", {31'd0, ready_o}, 32'd1);
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    ready_i = 1'b1;
    tick();
    chk("flush no reappear", {31'd0, valid_o}, 32'd0);

    // illegal encodings and JAL
    drive(1'b1, 32'h300, 32'h0000_0000);
    tick();
    chk("ill zero", {31'd0, illegal_o}, 32'd1);
    drive(1'b1, 32'h304, 32'hFFFF_FFFF);
    tick();
    chk("ill ones", {31'd0, illegal_o}, 32'd1);
    drive(1'b1, 32'h308, 32'h0080_00EF);
    tick();
    chk("jal rs1", {27'd0, rs1_o}, 32'd0);
    chk("jal illegal", {31'd0, illegal_o}, 32'd0);
    drive(1'b0, '0, '0);
    tick();

    // randomized handshake, flush and instruction mix
    for (int c = 0; c < 10000; c++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(11)];
      drive($urandom_range(3) != 0, $urandom, w);
      ready_i = ($urandom_range(2) != 0);
      flush_i = ($urandom_range(31) == 0);
      tick();
    end
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("drained", {31'd0, valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
